// File: rtl/six_bit_frame_packer.sv
// Edge-detects 6-bit word strobes, packs 16 words into 12 bytes, queues up to two
// complete frames and emits them as {header, 12 data bytes[, checksum]} over valid/ready.
// Optional checksum byte: define FRAME_CHECKSUM_EN.
module six_bit_frame_packer #(
    parameter logic [15:0] GAP_MAX = 16'd1000,
    parameter logic [3:0]  HDR_NIB = 4'hA
) (
    input  logic       clk80,
    input  logic       reset,
    input  logic [5:0] iData,
    input  logic       iVal,
    output logic [7:0] oData,
    output logic       oVal,
    input  logic       iRdy,
    output logic       oDrop
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HEAD = 3'd1,
        S_DATA = 3'd2,
`ifdef FRAME_CHECKSUM_EN
        S_SUM  = 3'd3,
`endif
        S_REL  = 3'd4
    } tx_state_t;

    function automatic logic [7:0] get_byte(input logic [95:0] v, input logic [3:0] j);
        return v[{j, 3'b000} +: 8];
    endfunction

    logic        val_prev_q;
    logic [3:0]  word_cnt_q, word_cnt_d;
    logic [15:0] gap_q, gap_d;
    logic [95:0] coll_q, coll_d;
    logic [95:0] slot_q [2];
    logic [3:0]  hdr_q [2];
    logic [1:0]  full_q, full_d;
    logic        wr_sel_q, rd_sel_q;
    logic [3:0]  f_cnt_q;
    logic        drop_q;
    logic [6:0]  wr_pos_s;
    logic        capture_s, commit_s, busy_drop_s, timeout_s, release_s, slot_free_s, hs_s;

    tx_state_t   state_q, state_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  odata_q, odata_d;
    logic        oval_q, oval_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]  chk_q, chk_d;
`endif

    assign capture_s = iVal && !val_prev_q;
    assign wr_pos_s  = 7'(word_cnt_q) * 7'd6;
    assign release_s = (state_q == S_REL);
    assign hs_s      = oval_q && iRdy;
    // A slot being released this very cycle already counts as free
    assign slot_free_s = !full_q[wr_sel_q] || (release_s && (rd_sel_q == wr_sel_q));

    // Word collection, gap timeout and frame commit decision
    always_comb begin
        coll_d      = coll_q;
        word_cnt_d  = word_cnt_q;
        gap_d       = gap_q;
        commit_s    = 1'b0;
        busy_drop_s = 1'b0;
        timeout_s   = 1'b0;
        if (capture_s) begin
            coll_d[wr_pos_s +: 6] = iData;
            gap_d = 16'd0;
            if (word_cnt_q == 4'd15) begin
                word_cnt_d = 4'd0;
                if (slot_free_s) begin
                    commit_s = 1'b1;
                end else begin
                    busy_drop_s = 1'b1;
                end
            end else begin
                word_cnt_d = word_cnt_q + 4'd1;
            end
        end else if (word_cnt_q != 4'd0) begin
            if (gap_q >= GAP_MAX - 16'd1) begin
                timeout_s  = 1'b1;
                word_cnt_d = 4'd0;
                gap_d      = 16'd0;
            end else begin
                gap_d = gap_q + 16'd1;
            end
        end else begin
            gap_d = gap_q;
        end
    end

    // Slot occupancy: release clears, commit sets (same slot -> stays full)
    always_comb begin
        full_d = full_q;
        if (release_s) begin
            full_d[rd_sel_q] = 1'b0;
        end else begin
            full_d = full_q;
        end
        if (commit_s) begin
            full_d[wr_sel_q] = 1'b1;
        end else begin
            full_d = full_d;
        end
    end

    // Collector and frame slot registers
    always_ff @(posedge clk80) begin
        if (reset) begin
            val_prev_q <= 1'b0;
            word_cnt_q <= 4'd0;
            gap_q      <= 16'd0;
            coll_q     <= 96'd0;
            slot_q[0]  <= 96'd0;
            slot_q[1]  <= 96'd0;
            hdr_q[0]   <= 4'd0;
            hdr_q[1]   <= 4'd0;
            full_q     <= 2'b00;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            f_cnt_q    <= 4'd0;
            drop_q     <= 1'b0;
        end else begin
            val_prev_q <= iVal;
            word_cnt_q <= word_cnt_d;
            gap_q      <= gap_d;
            coll_q     <= coll_d;
            full_q     <= full_d;
            drop_q     <= busy_drop_s | timeout_s;
            if (commit_s) begin
                slot_q[wr_sel_q] <= coll_d;
                hdr_q[wr_sel_q]  <= f_cnt_q;
                f_cnt_q          <= f_cnt_q + 4'd1;
                wr_sel_q         <= ~wr_sel_q;
            end
            if (release_s) begin
                rd_sel_q <= ~rd_sel_q;
            end
        end
    end

    // Transmit FSM: next state and next registered outputs
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        odata_d    = odata_q;
        oval_d     = oval_q;
`ifdef FRAME_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            S_IDLE: begin
                oval_d  = 1'b0;
                odata_d = 8'd0;
                if (full_q[rd_sel_q]) begin
                    state_d    = S_HEAD;
                    byte_idx_d = 4'd0;
                    oval_d     = 1'b1;
                    odata_d    = {HDR_NIB, hdr_q[rd_sel_q]};
`ifdef FRAME_CHECKSUM_EN
                    chk_d      = {HDR_NIB, hdr_q[rd_sel_q]};
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HEAD: begin
                if (hs_s) begin
                    state_d    = S_DATA;
                    byte_idx_d = 4'd0;
                    odata_d    = get_byte(slot_q[rd_sel_q], 4'd0);
`ifdef FRAME_CHECKSUM_EN
                    chk_d      = chk_q ^ get_byte(slot_q[rd_sel_q], 4'd0);
`endif
                end else begin
                    state_d = S_HEAD;
                end
            end
            S_DATA: begin
                if (hs_s && (byte_idx_q == 4'd11)) begin
`ifdef FRAME_CHECKSUM_EN
                    state_d = S_SUM;
                    odata_d = chk_q;
`else
                    state_d = S_REL;
                    oval_d  = 1'b0;
                    odata_d = 8'd0;
`endif
                end else if (hs_s) begin
                    byte_idx_d = byte_idx_q + 4'd1;
                    odata_d    = get_byte(slot_q[rd_sel_q], byte_idx_q + 4'd1);
`ifdef FRAME_CHECKSUM_EN
                    chk_d      = chk_q ^ get_byte(slot_q[rd_sel_q], byte_idx_q + 4'd1);
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef FRAME_CHECKSUM_EN
            S_SUM: begin
                if (hs_s) begin
                    state_d = S_REL;
                    oval_d  = 1'b0;
                    odata_d = 8'd0;
                end else begin
                    state_d = S_SUM;
                end
            end
`endif
            S_REL: begin
                state_d = S_IDLE;
                oval_d  = 1'b0;
                odata_d = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                oval_d  = 1'b0;
                odata_d = 8'd0;
            end
        endcase
    end

    // Transmit FSM registers
    always_ff @(posedge clk80) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_idx_q <= 4'd0;
            odata_q    <= 8'd0;
            oval_q     <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            chk_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            odata_q    <= odata_d;
            oval_q     <= oval_d;
`ifdef FRAME_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign oData = odata_q;
    assign oVal  = oval_q;
    assign oDrop = drop_q;

endmodule

// File: tb/tb_six_bit_frame_packer.sv
// Randomized bench for six_bit_frame_packer against a frame-level reference model,
// plus literal expectations for the documented frames.
module tb_six_bit_frame_packer;

    localparam int GAP = 1000;
`ifdef FRAME_CHECKSUM_EN
    localparam int FL = 14;
`else
    localparam int FL = 13;
`endif

    logic       clk80 = 1'b0;
    logic       reset;
    logic [5:0] iData;
    logic       iVal;
    logic       iRdy;
    logic [7:0] oData;
    logic       oVal;
    logic       oDrop;

    always #5 clk80 = ~clk80;

    six_bit_frame_packer dut (
        .clk80(clk80), .reset(reset), .iData(iData), .iVal(iVal),
        .oData(oData), .oVal(oVal), .iRdy(iRdy), .oDrop(oDrop)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int drop_cnt = 0;
    bit rnd_rdy = 1'b0;

    // reference model state
    int         m_words, m_gap, m_fcnt, m_phase, m_pos, m_nfull;
    logic       m_vprev;
    logic [5:0] m_coll [16];
    logic [7:0] m_pend [$];
    logic [7:0] e_data;
    logic       e_val, e_drop;
    logic [7:0] log_q [$];

    task automatic build_frame();
        logic [95:0] v;
        logic [95:0] t;
        logic [7:0]  b;
        logic [7:0]  x;
        v = '0;
        for (int k = 0; k < 16; k++) v = v | (96'(m_coll[k]) << (6 * k));
        x = {4'hA, 4'(m_fcnt)};
        m_pend.push_back(x);
        for (int j = 0; j < 12; j++) begin
            t = v >> (8 * j);
            b = t[7:0];
            x = x ^ b;
            m_pend.push_back(b);
        end
        if (FL == 14) m_pend.push_back(x);
    endtask

    task automatic model_step();
        bit cap, rel, commit, drop;
        int nold;
        if (reset) begin
            m_words = 0; m_gap = 0; m_fcnt = 0; m_phase = 0; m_pos = 0; m_nfull = 0;
            m_vprev = 1'b0; m_pend.delete();
            e_val = 1'b0; e_data = 8'h00; e_drop = 1'b0;
            return;
        end
        cap = iVal && !m_vprev;
        m_vprev = iVal;
        rel = (m_phase == 2);
        nold = m_nfull;
        commit = 1'b0;
        drop = 1'b0;
        case (m_phase)
            0: if (nold > 0) begin
                   m_phase = 1; m_pos = 0; e_val = 1'b1; e_data = m_pend[0];
               end else begin
                   e_val = 1'b0; e_data = 8'h00;
               end
            1: if (e_val && iRdy) begin
                   m_pos++;
                   if (m_pos == FL) begin
                       m_phase = 2; e_val = 1'b0; e_data = 8'h00;
                   end else begin
                       e_data = m_pend[m_pos];
                   end
               end
            default: begin
                m_phase = 0; e_val = 1'b0; e_data = 8'h00;
                repeat (FL) void'(m_pend.pop_front());
            end
        endcase
        if (cap) begin
            m_coll[m_words] = iData;
            m_gap = 0;
            if (m_words == 15) begin
                m_words = 0;
                if (nold < 2 || rel) begin
                    build_frame();
                    m_fcnt = (m_fcnt + 1) % 16;
                    commit = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else begin
                m_words++;
            end
        end else if (m_words != 0) begin
            m_gap++;
            if (m_gap >= GAP) begin
                drop = 1'b1; m_words = 0; m_gap = 0;
            end
        end
        m_nfull = nold + int'(commit) - int'(rel);
        e_drop = drop;
    endtask

    task automatic step(input logic v, input logic [5:0] d);
        iVal = v;
        iData = d;
        if (rnd_rdy) iRdy = 1'($urandom_range(0, 1));
        if (!reset && oVal && iRdy) log_q.push_back(oData);
        @(posedge clk80);
        model_step();
        #1;
        cyc++;
        vectors++;
        if (oDrop) drop_cnt++;
        if (oVal !== e_val || oData !== e_data || oDrop !== e_drop) begin
            miscompares++;
            $display("FAIL cycle%0d outputs: got val=%b data=%h drop=%b, expected val=%b data=%h drop=%b",
                     cyc, oVal, oData, oDrop, e_val, e_data, e_drop);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [5:0] d, input int hold, input int gap);
        repeat (hold) step(1'b1, d);
        repeat (gap) step(1'b0, 6'd0);
    endtask

    task automatic send_random_frame(input int nwords);
        for (int k = 0; k < nwords; k++)
            send_word(6'($urandom_range(0, 63)), $urandom_range(1, 4), $urandom_range(1, 3));
    endtask

    initial begin
        int base;
        int waited;
        reset = 1'b1; iRdy = 1'b1; iVal = 1'b0; iData = 6'd0;
        repeat (3) step(1'b0, 6'd0);
        chk("reset_oVal", int'(oVal), 0);
        chk("reset_oData", int'(oData), 0);
        chk("reset_oDrop", int'(oDrop), 0);
        reset = 1'b0;

        // frame 1: all-ones words
        base = log_q.size(); drop_cnt = 0;
        for (int k = 0; k < 16; k++) send_word(6'h3F, 4, 1);
        repeat (25) step(1'b0, 6'd0);
        chk("f1_len", log_q.size() - base, FL);
        chk("f1_hdr", int'(log_q[base]), 'hA0);
        for (int j = 1; j <= 12; j++) chk("f1_data", int'(log_q[base + j]), 'hFF);
        if (FL == 14) chk("f1_sum", int'(log_q[base + 13]), 'hA0);
        chk("f1_nodrop", drop_cnt, 0);

        // frame 2: two low words set
        base = log_q.size();
        send_word(6'h01, 2, 1); send_word(6'h01, 2, 1);
        for (int k = 2; k < 16; k++) send_word(6'h00, 2, 1);
        repeat (25) step(1'b0, 6'd0);
        chk("f2_hdr", int'(log_q[base]), 'hA1);
        chk("f2_b0", int'(log_q[base + 1]), 'h41);
        chk("f2_b11", int'(log_q[base + 12]), 'h00);
        if (FL == 14) chk("f2_sum", int'(log_q[base + 13]), 'hE0);

        // long strobe is one word; it then times out
        drop_cnt = 0;
        send_word(6'h15, 20, 0);
        repeat (GAP + 5) step(1'b0, 6'd0);
        chk("long_strobe_drop", drop_cnt, 1);

        // partial frame timeout, then a good frame
        drop_cnt = 0;
        send_random_frame(5);
        repeat (GAP + 5) step(1'b0, 6'd0);
        chk("gap_drop", drop_cnt, 1);
        base = log_q.size();
        send_random_frame(16);
        repeat (25) step(1'b0, 6'd0);
        chk("f3_hdr", int'(log_q[base]), 'hA2);

        // stalled output: second frame queued, third dropped
        drop_cnt = 0; base = log_q.size(); iRdy = 1'b0;
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 16; k++) send_word(6'($urandom_range(0, 63)), 1, 1);
        repeat (5) step(1'b0, 6'd0);
        chk("stall_oVal", int'(oVal), 1);
        chk("stall_oData", int'(oData), 'hA3);
        chk("busy_drop", drop_cnt, 1);
        iRdy = 1'b1;
        repeat (50) step(1'b0, 6'd0);
        chk("stall_len", log_q.size() - base, 2 * FL);
        chk("stall_hdr1", int'(log_q[base]), 'hA3);
        chk("stall_hdr2", int'(log_q[base + FL]), 'hA4);

        // random traffic with random backpressure
        rnd_rdy = 1'b1;
        send_random_frame(80);
        rnd_rdy = 1'b0; iRdy = 1'b1;
        repeat (GAP + 60) step(1'b0, 6'd0);

        // reset while data byte 5 is presented
        send_random_frame(16);
        waited = 0;
        while (!(m_phase == 1 && m_pos == 6) && waited < 200) begin
            step(1'b0, 6'd0);
            waited++;
        end
        chk("reach_byte5", int'(waited < 200), 1);
        drop_cnt = 0;
        reset = 1'b1;
        step(1'b0, 6'd0);
        reset = 1'b0;
        chk("rst_mid_oVal", int'(oVal), 0);
        repeat (5) step(1'b0, 6'd0);
        base = log_q.size();
        send_random_frame(16);
        repeat (25) step(1'b0, 6'd0);
        chk("post_rst_hdr", int'(log_q[base]), 'hA0);
        chk("post_rst_nodrop", drop_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
